// File: rtl/bcd_seg_converter.sv
// rtl/bcd_seg_converter.sv - iterative binary-to-BCD converter driving registered active-low 7-segment digits
module bcd_seg_converter #(
  parameter int W      = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [W-1:0]          value,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int CW = $clog2(W + 1);
  localparam int BW = 4 * DIGITS;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic {IDLE, CONV} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [W-1:0]        bin_q, bin_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic                sticky_q, sticky_d;
  logic                blank_q, blank_d;
  logic [7*DIGITS-1:0] seg_q, seg_d;
  logic                overflow_q, overflow_d;
  logic                done_q, done_d;

  logic [BW-1:0]       bcd_adj;
  logic [BW-1:0]       bcd_sh;
  logic [W-1:0]        bin_sh;
  logic                shout;
  logic                lead;
  logic [3:0]          digit;
  logic [7*DIGITS-1:0] seg_new;
  logic                last;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

  assign last = (cnt_q == CW'(1));

  // One double-dabble step plus the display image that this step would produce if it is the last
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
    {shout, bcd_sh, bin_sh} = {bcd_adj, bin_q, 1'b0};

    // Walk from the top digit down; lead stays set while only zeros have been seen
    lead    = 1'b1;
    digit   = 4'd0;
    seg_new = '1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      digit = bcd_sh[4*k +: 4];
      if (digit != 4'd0 || k == 0) begin
        lead = 1'b0;
      end
      if (sticky_q | shout) begin
        seg_new[7*k +: 7] = SEG_DASH;
      end else if (blank_q && lead) begin
        seg_new[7*k +: 7] = SEG_BLANK;
      end else begin
        seg_new[7*k +: 7] = seg_code(digit);
      end
    end
  end

  // Next-state logic: accept a request in IDLE, shift one bit per cycle in CONV
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    sticky_d   = sticky_q;
    blank_d    = blank_q;
    seg_d      = seg_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d    = value;
          blank_d  = blank_lz;
          bcd_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = CW'(W);
          state_d  = CONV;
        end
      end
      CONV: begin
        bcd_d    = bcd_sh;
        bin_d    = bin_sh;
        sticky_d = sticky_q | shout;
        cnt_d    = cnt_q - CW'(1);
        if (last) begin
          state_d    = IDLE;
          done_d     = 1'b1;
          seg_d      = seg_new;
          overflow_d = sticky_q | shout;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any conversion and blanks the display
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      sticky_q   <= 1'b0;
      blank_q    <= 1'b0;
      seg_q      <= '1;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      sticky_q   <= sticky_d;
      blank_q    <= blank_d;
      seg_q      <= seg_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q == CONV);
  assign done     = done_q;
  assign overflow = overflow_q;
  assign seg      = seg_q;

endmodule
